// File: rtl/core_pkg.sv
// core_pkg: definitions shared across the pipeline stages.
//   XLEN_DEFAULT  - default datapath / address width
//   NOP_INSTR     - bubble encoding (addi x0,x0,0)
//   fetch_state_t - fetch-stage FSM states
package core_pkg;

   localparam int unsigned XLEN_DEFAULT = 64;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      HOLD    = 2'b01,
      DISCARD = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
//   req   - fetch request (master -> slave)
//   addr  - fetch address, stable while req & !ready (master -> slave)
//   ready - response strobe, rdata valid in the same cycle (slave -> master)
//   rdata - fetched instruction (slave -> master)
interface fetch_stage_if #(
   parameter int unsigned XLEN = 64
);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic [31:0]     rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: generic pipeline register carrying PC, instruction and valid.
//   clk, reset          - clock, async active-high reset
//   write_en            - load pc_in/instr_in/valid_in; 0 = hold
//   flush               - load a bubble; wins over write_en
//   pc_in, instr_in,
//   valid_in            - next contents
//   pc, instr, valid    - registered contents (bubble = {0, NOP_INSTR, 0})
module if_id_reg #(
   parameter int unsigned XLEN      = 64,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            write_en,
   input  logic            flush,
   input  logic [XLEN-1:0] pc_in,
   input  logic [31:0]     instr_in,
   input  logic            valid_in,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr,
   output logic            valid
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= '0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (flush) begin
         pc    <= '0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (write_en) begin
         pc    <= pc_in;
         instr <= instr_in;
         valid <= valid_in;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, the fetch FSM, the
// hold buffer for responses that arrive during a stall, and the IF/ID
// pipeline register.
//   clk, reset     - core clock, async active-high reset
//   pc_write       - hazard unit; 0 = hold PC
//   if_id_write    - hazard unit; 0 = hold IF/ID
//   branch_taken   - redirect from EX; also flushes IF/ID
//   branch_target  - redirect address
//   imem           - instruction-memory bus (master side)
//   if_id_pc       - PC of the instruction in IF/ID
//   if_id_instr    - instruction in IF/ID
//   if_id_valid    - 0 = bubble
module fetch_stage
   import core_pkg::*;
#(
   parameter int unsigned XLEN      = core_pkg::XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pc_write,
   input  logic                 if_id_write,
   input  logic                 branch_taken,
   input  logic [XLEN-1:0]      branch_target,
   fetch_stage_if.master        imem,
   output logic [XLEN-1:0]      if_id_pc,
   output logic [31:0]          if_id_instr,
   output logic                 if_id_valid
);

   fetch_state_t    state, state_next;
   logic [XLEN-1:0] pc, pc_next;
   logic [XLEN-1:0] redirect_pc, redirect_next;
   logic [31:0]     hold_buf, hold_next;
   logic [31:0]     ifid_instr_in;
   logic            ifid_we, ifid_flush;
   logic            stall, accept;
   logic [XLEN-1:0] pc_plus4;

   // Either hazard enable low is treated as a full stall.
   assign stall    = ~(pc_write & if_id_write);
   assign pc_plus4 = pc + XLEN'(4);

   // Gated by reset so no request is seen while reset is held; goes high
   // in the first cycle after release.
   assign imem.req  = ~reset & ((state == FETCH) || (state == DISCARD));
   assign imem.addr = pc;
   assign accept    = imem.req & imem.ready;

   always_comb begin
      state_next    = state;
      pc_next       = pc;
      redirect_next = redirect_pc;
      hold_next     = hold_buf;
      ifid_we       = 1'b0;
      ifid_flush    = 1'b0;
      ifid_instr_in = imem.rdata;

      case (state)
         FETCH: begin
            if (accept) begin
               if (branch_taken) begin
                  pc_next    = branch_target;
                  ifid_flush = 1'b1;
               end else if (!stall) begin
                  ifid_we       = 1'b1;
                  ifid_instr_in = imem.rdata;
                  pc_next       = pc_plus4;
               end else begin
                  hold_next  = imem.rdata;
                  state_next = HOLD;
               end
            end else begin
               if (branch_taken) begin
                  // Request to the old pc is still in flight; remember the
                  // target and swallow the stale response in DISCARD.
                  redirect_next = branch_target;
                  ifid_flush    = 1'b1;
                  state_next    = DISCARD;
               end else if (!stall) begin
                  ifid_flush = 1'b1;
               end
            end
         end

         HOLD: begin
            if (branch_taken) begin
               hold_next  = '0;
               pc_next    = branch_target;
               ifid_flush = 1'b1;
               state_next = FETCH;
            end else if (!stall) begin
               ifid_we       = 1'b1;
               ifid_instr_in = hold_buf;
               pc_next       = pc_plus4;
               state_next    = FETCH;
            end
         end

         DISCARD: begin
            if (accept) begin
               pc_next    = branch_taken ? branch_target : redirect_pc;
               state_next = FETCH;
            end else if (branch_taken) begin
               redirect_next = branch_target;
            end
            ifid_flush = branch_taken | ~stall;
         end

         default: begin
            state_next = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         redirect_pc <= '0;
         hold_buf    <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         redirect_pc <= redirect_next;
         hold_buf    <= hold_next;
      end
   end

   if_id_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .write_en (ifid_we),
      .flush    (ifid_flush),
      .pc_in    (pc),
      .instr_in (ifid_instr_in),
      .valid_in (1'b1),
      .pc       (if_id_pc),
      .instr    (if_id_instr),
      .valid    (if_id_valid)
   );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core: owns the PC register and the IF/ID pipeline register.
- Consumes pc_write / if_id_write from the hazard detection unit, and branch redirects from EX.
- Talks to instruction memory over a req/ready handshake with variable latency.
- Drives the IF/ID outputs read by decode: PC, instruction and valid bit.

Parameters:
- XLEN, 64, width of PC and addresses.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, encoding used for bubbles (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_write  in  1  from hazard unit; 0 = hold PC.
- if_id_write  in  1  from hazard unit; 0 = hold IF/ID.
- branch_taken  in  1  redirect request from EX; also flushes IF/ID.
- branch_target  in  XLEN  redirect address, valid with branch_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; stable while imem_req is high and imem_ready is low.
- imem_ready  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- if_id_pc  out  XLEN  PC of the instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  0 = bubble.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, state=FETCH.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - Hold buffer cleared, redirect_pc=0.
  - imem_req goes high in the first cycle after reset deasserts.
- stall = ~(pc_write & if_id_write). The hazard unit drives both low together; either low counts as a stall.
- imem_req = (state==FETCH || state==DISCARD). imem_addr = pc.
- A response is accepted in any cycle where imem_req & imem_ready.
- FETCH:
  - ready & branch_taken: drop rdata; pc<=branch_target; IF/ID<=bubble; stay FETCH.
  - ready & !stall: IF/ID<={pc, rdata, 1}; pc<=pc+4 (mod 2^XLEN); stay FETCH.
  - ready & stall: hold_buf<=rdata; IF/ID holds; pc holds; ->HOLD.
  - !ready & branch_taken: redirect_pc<=branch_target; IF/ID<=bubble; ->DISCARD.
  - !ready & !stall: IF/ID<=bubble.
  - !ready & stall: IF/ID holds.
- HOLD (imem_req low):
  - branch_taken: drop hold_buf; pc<=branch_target; IF/ID<=bubble; ->FETCH.
  - !stall: IF/ID<={pc, hold_buf, 1}; pc<=pc+4; ->FETCH.
  - stall: remain in HOLD; all registers hold.
- DISCARD (request to the old pc still outstanding; address stays stable):
  - branch_taken without ready: redirect_pc<=newest target.
  - ready: drop rdata; pc<=(branch_taken ? branch_target : redirect_pc); ->FETCH.
  - IF/ID<=bubble unless stall is high, in which case IF/ID holds.
- Priority: branch_taken > stall > normal. A flush overrides if_id_write=0.
- Throughput: with imem_ready tied high, one instruction per cycle. An instruction accepted in cycle N is visible in IF/ID in cycle N+1.
- At most one outstanding request. The unused encoding of the 2-bit state goes to FETCH.
- Reset asserted mid-request abandons the request. No response is expected afterwards, and any late ready is ignored until imem_req is reasserted.

Decomposition:
- Shared package core_pkg:
  - NOP_INSTR constant.
  - fetch_state_t enum {FETCH, HOLD, DISCARD}.
  - XLEN default.
- One natural sub-module: if_id_reg, holding the PC, instruction and valid registers with write-enable and flush inputs. It is reusable by the pipeline-register family.
- FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset: hold reset 3 cycles, then release with imem_ready=1 and rdata=0x00500093. imem_addr must read 0x0, 0x4, 0x8 on successive cycles; if_id_valid rises one cycle after the first request; if_id_pc=0x0, if_id_instr=0x00500093.
- Load-use stall, zero-wait memory: pc=0x10, pc_write=if_id_write=0 for 1 cycle. IF/ID holds 0xC; the instruction at 0x10 is buffered and imem_req drops. The next cycle IF/ID shows 0x10 and imem_addr=0x14.
- Wait states: imem_ready low for 2 cycles at pc=0x20. imem_addr stays 0x20; two bubbles appear (valid=0, instr=0x13); then IF/ID shows pc 0x20.
- Branch while waiting: request to 0x30 outstanding, branch_taken with target 0x100, ready arrives 2 cycles later with 0xDEADBEEF. That data is never valid in IF/ID; the next imem_addr is 0x100.
- Branch during HOLD together with a stall: hold_buf is dropped, the flush wins over the stall (valid=0), and imem_addr=branch_target on the next cycle.
- Reset mid-DISCARD: all outputs return to reset values immediately (async), and a ready pulse arriving during reset does not update pc.
